// File: rtl/scan_chain_shifter_if.sv
// Word streams between the management side and the scan-chain shifter:
// din carries words to serialise, dout carries captured readback words.
interface scan_chain_shifter_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    // Producer of din / consumer of dout.
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    // The shifter itself.
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/scan_chain_shifter.sv
// Scan-chain stimulus/readback engine: serialises din words LSB-first into
// sc_head, one shift_en pulse per bit, and packs sc_tail bits into dout words.
module scan_chain_shifter #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [LEN_W-1:0] chain_len,
    scan_chain_shifter_if.slave bus,
    output logic             sc_head,
    input  logic             sc_tail,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);
    localparam int unsigned IDX_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StDrain,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

    // State register; reset abandons any transfer with no done pulse.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            shreg_q     <= '0;
            cap_q       <= '0;
            bit_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    // Next-state logic: fetch a word, shift it out bit by bit, drain the capture.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shreg_d     = shreg_q;
        cap_d       = cap_q;
        bit_idx_d   = bit_idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (chain_len != '0) begin
                        remaining_d = chain_len;
                        state_d     = StFetch;
                    end else begin
                        // Empty chain: just report completion.
                        state_d = StFinish;
                    end
                end
            end
            StFetch: begin
                if (bus.din_valid) begin
                    shreg_d   = bus.din;
                    bit_idx_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // sc_tail still shows the pre-shift tail at this edge.
                cap_d[bit_idx_q] = sc_tail;
                shreg_d          = shreg_q >> 1;
                bit_idx_d        = bit_idx_q + 1'b1;
                remaining_d      = remaining_q - 1'b1;
                if (bit_idx_q == IDX_W'(WORD_W - 1) || remaining_q == LEN_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.dout_ready) begin
                    cap_d   = '0;
                    state_d = (remaining_q == '0) ? StFinish : StFetch;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        shift_en       = (state_q == StShift);
        sc_head        = shift_en & shreg_q[0];
        busy           = (state_q == StFetch) || (state_q == StShift) || (state_q == StDrain);
        done           = (state_q == StFinish);
        bus.din_ready  = (state_q == StFetch);
        bus.dout_valid = (state_q == StDrain);
        bus.dout       = cap_q;
    end
endmodule
